// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: hh:mm:ss timekeeper with RUN/SET_HR/SET_MIN mode FSM and edit-field blink.
// Ports: clk_in/rst_n clock and async active-low reset; tick per-second-fraction enable;
// btn_mode/btn_inc debounced pulses; hours/minutes/seconds binary time; mode current FSM state;
// disp_on blink enable for the edited field; sec_pulse one-cycle pulse on each RUN second.
module clock_time_ctrl #(
  parameter int TICKS_PER_SEC = 4,
  parameter int SUBSEC_W      = 8
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       disp_on,
  output logic       sec_pulse
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} mode_t;
  mode_t               state, state_nx;
  logic [SUBSEC_W-1:0] subsec, subsec_nx;
  logic [4:0]          hours_nx;
  logic [5:0]          minutes_nx, seconds_nx;
  logic                disp_nx, pulse_nx;
  logic                sec_end, min_end;
  assign mode    = state;
  assign sec_end = seconds == 6'd59;
  assign min_end = minutes == 6'd59;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state     <= RUN;
      subsec    <= '0;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      disp_on   <= 1'b1;
      sec_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      subsec    <= subsec_nx;
      hours     <= hours_nx;
      minutes   <= minutes_nx;
      seconds   <= seconds_nx;
      disp_on   <= disp_nx;
      sec_pulse <= pulse_nx;
    end
  always_comb begin
    state_nx   = state;
    subsec_nx  = subsec;
    hours_nx   = hours;
    minutes_nx = minutes;
    seconds_nx = seconds;
    disp_nx    = disp_on;
    pulse_nx   = 1'b0;
    case (state)
      RUN: begin
        disp_nx = 1'b1;
        // A tick coinciding with btn_mode is still counted before entering SET_HR.
        if (tick) begin
          if (subsec < SUBSEC_W'(TICKS_PER_SEC - 1)) subsec_nx = subsec + SUBSEC_W'(1);
          else begin
            subsec_nx  = '0;
            pulse_nx   = 1'b1;
            seconds_nx = sec_end ? 6'd0 : seconds + 6'd1;
            if (sec_end) minutes_nx = min_end ? 6'd0 : minutes + 6'd1;
            if (sec_end && min_end) hours_nx = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
          end
        end
        if (btn_mode) state_nx = SET_HR;
      end
      SET_HR: begin
        if (btn_mode) begin
          state_nx = SET_MIN;
          disp_nx  = 1'b1;
        end else begin
          if (btn_inc) hours_nx = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
          if (tick) disp_nx = ~disp_on;
        end
      end
      SET_MIN: begin
        // Leaving edit restarts the second so the set time begins at :00.
        if (btn_mode) begin
          state_nx   = RUN;
          disp_nx    = 1'b1;
          seconds_nx = '0;
          subsec_nx  = '0;
        end else begin
          if (btn_inc) minutes_nx = min_end ? 6'd0 : minutes + 6'd1;
          if (tick) disp_nx = ~disp_on;
        end
      end
      default: begin
        state_nx = RUN;
        disp_nx  = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: scoreboard bench for clock_time_ctrl with a behavioural time/mode model.
module tb_clock_time_ctrl;
  localparam int TPS = 4;
  logic       clk_in = 1'b0, rst_n = 1'b0, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] mode;
  logic       disp_on, sec_pulse;
  int         n_vec = 0, n_err = 0;
  int         m_h, m_m, m_s, m_ss, m_mode, m_disp, m_pulse;
  logic [20:0] sb[$];
  localparam logic [20:0] RST_VAL = {5'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b0};

  clock_time_ctrl #(.TICKS_PER_SEC(TPS), .SUBSEC_W(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hours(hours), .minutes(minutes), .seconds(seconds), .mode(mode),
    .disp_on(disp_on), .sec_pulse(sec_pulse)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [20:0] obs();
    return {hours, minutes, seconds, mode, disp_on, sec_pulse};
  endfunction

  function automatic logic [20:0] pack_model();
    return {5'(m_h), 6'(m_m), 6'(m_s), 2'(m_mode), 1'(m_disp), 1'(m_pulse)};
  endfunction

  task automatic model_reset();
    {m_h, m_m, m_s, m_ss, m_mode, m_pulse} = '0;
    m_disp = 1;
    sb.delete();
  endtask

  task automatic model_step(input bit t, input bit bm, input bit bi);
    m_pulse = 0;
    if (m_mode == 0) begin
      if (t) begin
        m_ss++;
        if (m_ss == TPS) begin
          m_ss = 0; m_pulse = 1; m_s++;
          if (m_s == 60) begin
            m_s = 0; m_m++;
            if (m_m == 60) begin
              m_m = 0; m_h = (m_h + 1) % 24;
            end
          end
        end
      end
      m_disp = 1;
      if (bm) m_mode = 1;
    end else if (bm) begin
      m_disp = 1;
      if (m_mode == 2) begin
        m_s = 0; m_ss = 0;
      end
      m_mode = (m_mode + 1) % 3;
    end else begin
      if (bi && m_mode == 1) m_h = (m_h + 1) % 24;
      if (bi && m_mode == 2) m_m = (m_m + 1) % 60;
      if (t) m_disp ^= 1;
    end
  endtask

  task automatic drive(input bit [2:0] c);
    {tick, btn_mode, btn_inc} = c;
    model_step(c[2], c[1], c[0]);
    sb.push_back(pack_model());
    @(posedge clk_in);
    #1;
    {tick, btn_mode, btn_inc} = 3'b000;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    got = obs();
    n_vec++;
    if (got !== RST_VAL) begin
      n_err++;
      $display("FAIL reset got=%h exp=%h", got, RST_VAL);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    bit [2:0] st[$];
    logic [20:0] exp;
    for (int i = 0; i < 4; i++) st.push_back(3'b100);
    st.push_back(3'b000);
    for (int i = 0; i < 236; i++) st.push_back(3'b100);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL run_step%0d got=%h exp=%h", i, obs(), exp);
      end
    end
    n_vec++;
    if (minutes !== 6'd1 || seconds !== 6'd0) begin
      n_err++;
      $display("FAIL run_240 got=%0d:%0d exp=1:0", minutes, seconds);
    end
  endtask

  task automatic test_set_hours();
    bit [2:0] st[$];
    logic [20:0] exp;
    st.push_back(3'b010);
    for (int i = 0; i < 25; i++) st.push_back(i < 8 ? 3'b101 : 3'b001);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL sethr_step%0d got=%h exp=%h", i, obs(), exp);
      end
    end
    n_vec++;
    if ({mode, hours, minutes, seconds, disp_on} !== {2'd1, 5'd1, 6'd1, 6'd0, 1'b1}) begin
      n_err++;
      $display("FAIL sethr_wrap got=m%0d %0d:%0d:%0d d%0d exp=m1 1:1:0 d1", mode, hours, minutes, seconds, disp_on);
    end
  endtask

  task automatic test_midnight();
    bit [2:0] st[$];
    logic [20:0] exp;
    for (int i = 0; i < 22; i++) st.push_back(3'b001);
    st.push_back(3'b010);
    for (int i = 0; i < 58; i++) st.push_back(3'b001);
    st.push_back(3'b010);
    for (int i = 0; i < 240; i++) st.push_back(3'b100);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL midnight_step%0d got=%h exp=%h", i, obs(), exp);
      end
    end
    n_vec++;
    if (obs() !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL midnight_wrap got=%h exp=%h", obs(), {5'd0, 6'd0, 6'd0, 2'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_set_minutes();
    bit [2:0] st[$];
    logic [20:0] exp;
    for (int i = 0; i < 70; i++) st.push_back(3'b100);
    st.push_back(3'b010);
    for (int i = 0; i < 12; i++) st.push_back(3'b001);
    st.push_back(3'b010);
    for (int i = 0; i < 34; i++) st.push_back(3'b001);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL setmin_pre%0d got=%h exp=%h", i, obs(), exp);
      end
    end
    n_vec++;
    if ({mode, hours, minutes, seconds} !== {2'd2, 5'd12, 6'd34, 6'd17}) begin
      n_err++;
      $display("FAIL setmin_1234 got=m%0d %0d:%0d:%0d exp=m2 12:34:17", mode, hours, minutes, seconds);
    end
    st.delete();
    for (int i = 0; i < 26; i++) st.push_back(3'b001);
    st.push_back(3'b010);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL setmin_wrap%0d got=%h exp=%h", i, obs(), exp);
      end
    end
    n_vec++;
    if ({mode, hours, minutes, seconds, disp_on} !== {2'd0, 5'd12, 6'd0, 6'd0, 1'b1}) begin
      n_err++;
      $display("FAIL setmin_exit got=m%0d %0d:%0d:%0d d%0d exp=m0 12:0:0 d1", mode, hours, minutes, seconds, disp_on);
    end
    st.delete();
    for (int i = 0; i < 4; i++) st.push_back(3'b100);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL setmin_subsec%0d got=%h exp=%h", i, obs(), exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit [2:0] st[$];
    logic [20:0] exp;
    st.push_back(3'b011);
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp || mode !== 2'd1 || hours !== 5'd12) begin
        n_err++;
        $display("FAIL sim_mode_inc got=%h exp=%h", obs(), exp);
      end
    end
    st.delete();
    st = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
    foreach (st[i]) begin
      drive(st[i]);
      exp = sb.pop_front();
      n_vec++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL sim_prep%0d got=%h exp=%h", i, obs(), exp);
      end
    end
    drive(3'b110);
    exp = sb.pop_front();
    n_vec++;
    if (obs() !== exp || {mode, seconds, sec_pulse} !== {2'd1, 6'd1, 1'b1}) begin
      n_err++;
      $display("FAIL sim_tick_mode got=%h exp=%h", obs(), exp);
    end
    drive(3'b100);
    exp = sb.pop_front();
    n_vec++;
    if (obs() !== exp || disp_on !== 1'b0) begin
      n_err++;
      $display("FAIL sim_blink got=%h exp=%h", obs(), exp);
    end
    drive(3'b110);
    exp = sb.pop_front();
    n_vec++;
    if (obs() !== exp || {mode, disp_on} !== {2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL sim_tick_entry got=%h exp=%h", obs(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [20:0] exp, got;
    drive(3'b010);
    exp = sb.pop_front();
    n_vec++;
    if (obs() !== exp) begin
      n_err++;
      $display("FAIL arst_torun got=%h exp=%h", obs(), exp);
    end
    drive(3'b010);
    exp = sb.pop_front();
    while (m_h != 7) begin
      drive(3'b001);
      exp = sb.pop_front();
    end
    n_vec++;
    if ({mode, hours} !== {2'd1, 5'd7} || obs() !== exp) begin
      n_err++;
      $display("FAIL arst_pre got=%h exp=%h", obs(), exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    n_vec++;
    if (got !== RST_VAL) begin
      n_err++;
      $display("FAIL arst_immediate got=%h exp=%h", got, RST_VAL);
    end
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    drive(3'b100);
    exp = sb.pop_front();
    n_vec++;
    if (obs() !== exp) begin
      n_err++;
      $display("FAIL arst_after got=%h exp=%h", obs(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_set_hours();
    test_midnight();
    test_set_minutes();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
